cmos_capture_data: RTL and testbench
====================================

CMOS_CAPTURE_DATA -- requirements
Module: cmos_capture_data

Interface
REQ-001 The block SHALL have one clock and SHALL use an asynchronous, active-low reset.
REQ-002 Parameter WAIT_FRAME SHALL default to 10 and SHALL set the number of vsync rising edges to discard after reset before output is enabled.
REQ-003 Port cam_pclk, input, 1 bit: the sole clock; all logic SHALL be on its rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 Port cam_vsync, input, 1 bit: camera frame sync, active high.
REQ-006 Port cam_href, input, 1 bit: camera line-valid, active high.
REQ-007 Port cam_data, input, 8 bits: camera byte stream, RGB565, high byte first.
REQ-008 Port h_disp, input, 11 bits: crop width in pixels.
REQ-009 Port v_disp, input, 11 bits: crop height in lines.
REQ-010 Port cmos_frame_vsync, output, 1 bit: gated, delayed vsync.
REQ-011 Port cmos_frame_href, output, 1 bit: gated, delayed href.
REQ-012 Port cmos_frame_valid, output, 1 bit: one-cycle pixel strobe.
REQ-013 Port cmos_frame_data, output, 16 bits: assembled RGB565 pixel.
REQ-014 Port line_err, output, 1 bit: sticky odd-byte-line flag.

Function
REQ-015 cam_vsync, cam_href and cam_data SHALL be registered twice (d0, d1); a vsync rising edge is vsync_d0 & ~vsync_d1.
REQ-016 frame_cnt SHALL count vsync rising edges and saturate at WAIT_FRAME; frame_ok SHALL be high when frame_cnt == WAIT_FRAME.
REQ-017 byte_flag SHALL toggle on every cycle with href_d0 high and SHALL clear when href_d0 is low.
REQ-018 With byte_flag=0 the byte SHALL latch into bits [15:8]; with byte_flag=1 it SHALL latch into bits [7:0] and raise an internal pixel pulse.
REQ-019 cmos_frame_valid SHALL assert for exactly one cycle, 2 cam_pclk cycles after the rising edge at which the second byte is on cam_data, with cmos_frame_data stable in that cycle.
REQ-020 x_cnt (11 bits) SHALL increment per pixel pulse, clear on href falling edge, and saturate at 2047.
REQ-021 y_cnt (11 bits) SHALL increment on href falling edge, clear on vsync rising edge, and saturate at 2047.
REQ-022 cmos_frame_valid SHALL equal pixel pulse & frame_ok & in_window.
REQ-023 cmos_frame_vsync SHALL equal vsync_d1 & frame_ok, and cmos_frame_href SHALL equal href_d1 & frame_ok.
REQ-024 If href falls while byte_flag=1, the half pixel SHALL be discarded (no strobe) and line_err SHALL be set.
REQ-025 line_err SHALL clear on the next vsync rising edge; a set and a clear in the same cycle SHALL resolve to set.
REQ-026 A vsync rising edge during href high SHALL clear x_cnt, y_cnt and byte_flag in that cycle.
REQ-027 h_disp or v_disp equal to 0 SHALL suppress all strobes; h_disp and v_disp changes SHALL take effect on the next pixel.

Reset
REQ-028 On rst_n low, all outputs, counters, byte_flag, frame_cnt and the data registers SHALL clear to 0 immediately.
REQ-029 Reset asserted mid-frame SHALL restart the WAIT_FRAME discard sequence.

Configuration
REQ-030 Macro CMOS_CROP_EN defined: in_window SHALL be (x_cnt < h_disp) && (y_cnt < v_disp), where x_cnt is the value before the increment.
REQ-031 Macro CMOS_CROP_EN undefined: in_window SHALL be constant 1, the x/y counters SHALL be omitted, and h_disp and v_disp SHALL be ignored.

Structure
REQ-032 Package cmos_pkg SHALL hold PIX_W=16, CNT_W=11 and WAIT_FRAME_DEF=10.
REQ-033 One sub-module, cmos_edge_det (2-flop delay plus rise/fall outputs), SHALL be instantiated for vsync and for href.

Verification
REQ-034 WAIT_FRAME=2, 3 frames of 4 lines x 8 bytes: no strobes in frames 1-2; frame 3 SHALL give 16 strobes.
REQ-035 Bytes 0xAB,0xCD SHALL produce cmos_frame_data=0xABCD, with the strobe 2 cycles after 0xCD is sampled.
REQ-036 CMOS_CROP_EN, h_disp=2, v_disp=1, 4x4 pixel frame: exactly 2 strobes, both in line 0.
REQ-037 A 7-byte line SHALL give 3 strobes and line_err=1 until the next vsync rising edge.
REQ-038 rst_n pulsed low mid-line in frame 5 (WAIT_FRAME=2): outputs SHALL be 0 at once, and no strobes until the 2nd subsequent frame.
REQ-039 CMOS_CROP_EN undefined, h_disp=0: all pixels SHALL be strobed.

Source files
------------

// File: rtl/cmos_pkg.sv
// Shared constants for the CMOS camera capture block.
//   PIX_W          : width of an assembled RGB565 pixel
//   CNT_W          : width of the crop counters and of h_disp/v_disp
//   WAIT_FRAME_DEF : default number of frames discarded after reset
package cmos_pkg;
    localparam int PIX_W          = 16;
    localparam int CNT_W          = 11;
    localparam int WAIT_FRAME_DEF = 10;
endpackage

// File: rtl/cmos_capture_data_if.sv
// Camera-side and frame-side signal bundle of cmos_capture_data.
//   cam_vsync/cam_href/cam_data : raw camera stream (RGB565, high byte first)
//   cmos_frame_vsync/href       : gated, delayed sync outputs
//   cmos_frame_valid/data       : one-cycle pixel strobe and assembled pixel
// Modports: master = camera source / pixel consumer, slave = capture block.
interface cmos_capture_data_if;
    import cmos_pkg::*;

    logic             cam_vsync;
    logic             cam_href;
    logic [7:0]       cam_data;
    logic             cmos_frame_vsync;
    logic             cmos_frame_href;
    logic             cmos_frame_valid;
    logic [PIX_W-1:0] cmos_frame_data;

    modport master (
        output cam_vsync, cam_href, cam_data,
        input  cmos_frame_vsync, cmos_frame_href, cmos_frame_valid, cmos_frame_data
    );

    modport slave (
        input  cam_vsync, cam_href, cam_data,
        output cmos_frame_vsync, cmos_frame_href, cmos_frame_valid, cmos_frame_data
    );
endinterface

// File: rtl/cmos_edge_det.sv
// Two-flop delay line with rise/fall detection on the delayed pair.
//   clk, rst_n : clock, asynchronous active-low reset
//   din        : raw input
//   d0, d1     : input delayed by one and two cycles
//   rise, fall : d0 & ~d1 and ~d0 & d1
module cmos_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic d0,
    output logic d1,
    output logic rise,
    output logic fall
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d0 <= 1'b0;
            d1 <= 1'b0;
        end else begin
            d0 <= din;
            d1 <= d0;
        end
    end

    assign rise = d0 & ~d1;
    assign fall = ~d0 & d1;
endmodule

// File: rtl/cmos_capture_data.sv
// CMOS camera capture: pairs RGB565 bytes into pixels, discards the first
// WAIT_FRAME frames after reset, and flags lines with an odd byte count.
//   cam_pclk  : pixel clock (all logic on its rising edge)
//   rst_n     : asynchronous active-low reset
//   cam       : camera stream in, gated frame signals out (slave modport)
//   h_disp    : crop width in pixels
//   v_disp    : crop height in lines
//   line_err  : sticky odd-byte-line flag, cleared by the next vsync rise
// Optional feature: define CMOS_CROP_EN to gate strobes to the
// h_disp x v_disp window; without it every pixel is strobed.
module cmos_capture_data
    import cmos_pkg::*;
#(
    parameter int WAIT_FRAME = WAIT_FRAME_DEF
) (
    input  logic               cam_pclk,
    input  logic               rst_n,
    cmos_capture_data_if.slave cam,
    input  logic [CNT_W-1:0]   h_disp,
    input  logic [CNT_W-1:0]   v_disp,
    output logic               line_err
);
    localparam int FRAME_CNT_W = (WAIT_FRAME < 1) ? 1 : $clog2(WAIT_FRAME + 1);

    logic vsync_d0, vsync_d1, vsync_rise, vsync_fall;
    logic href_d0, href_d1, href_rise, href_fall;

    cmos_edge_det u_vsync_det (
        .clk  (cam_pclk),
        .rst_n(rst_n),
        .din  (cam.cam_vsync),
        .d0   (vsync_d0),
        .d1   (vsync_d1),
        .rise (vsync_rise),
        .fall (vsync_fall)
    );

    cmos_edge_det u_href_det (
        .clk  (cam_pclk),
        .rst_n(rst_n),
        .din  (cam.cam_href),
        .d0   (href_d0),
        .d1   (href_d1),
        .rise (href_rise),
        .fall (href_fall)
    );

    logic [7:0]             data_d0_reg, data_d1_reg;
    logic [FRAME_CNT_W-1:0] frame_cnt_reg;
    logic                   frame_ok;
    logic                   byte_flag_reg;
    logic [PIX_W-1:0]       pix_reg;
    logic                   pix_pulse_reg;
    logic                   in_window;
    logic                   valid_reg;
    logic [PIX_W-1:0]       data_out_reg;
    logic                   line_err_reg;

    // Edge flavours not needed for this block, plus the second data stage
    // kept only for alignment with the sync delay line.
    logic unused_sink;
    assign unused_sink = ^{data_d1_reg, vsync_fall, href_rise};

    always_ff @(posedge cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            data_d0_reg <= '0;
            data_d1_reg <= '0;
        end else begin
            data_d0_reg <= cam.cam_data;
            data_d1_reg <= data_d0_reg;
        end
    end

    // Frame counter saturates so frame_ok stays high until the next reset.
    assign frame_ok = (frame_cnt_reg == FRAME_CNT_W'(WAIT_FRAME));

    always_ff @(posedge cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_reg <= '0;
        end else if (vsync_rise && !frame_ok) begin
            frame_cnt_reg <= frame_cnt_reg + FRAME_CNT_W'(1);
        end
    end

    // byte_flag = 1 means the high byte of the current pixel is held.
    // A vsync rise restarts pairing even in the middle of a line.
    always_ff @(posedge cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            byte_flag_reg <= 1'b0;
            pix_reg       <= '0;
            pix_pulse_reg <= 1'b0;
        end else begin
            byte_flag_reg <= href_d0 & ~byte_flag_reg & ~vsync_rise;
            pix_pulse_reg <= href_d0 & byte_flag_reg & ~vsync_rise;
            if (href_d0 && !vsync_rise) begin
                if (!byte_flag_reg) pix_reg[15:8] <= data_d0_reg;
                else                pix_reg[7:0]  <= data_d0_reg;
            end
        end
    end

    // A line ending with a held high byte drops it and raises line_err;
    // setting takes priority over the vsync clear.
    always_ff @(posedge cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            line_err_reg <= 1'b0;
        end else if (href_fall && byte_flag_reg) begin
            line_err_reg <= 1'b1;
        end else if (vsync_rise) begin
            line_err_reg <= 1'b0;
        end
    end

`ifdef CMOS_CROP_EN
    logic [CNT_W-1:0] x_cnt_reg, y_cnt_reg;

    // x is the index of the pixel being strobed (pre-increment), y the line
    // index since the last vsync rise. A line's last pixel pulse coincides
    // with the href fall, where the clear wins.
    always_ff @(posedge cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            x_cnt_reg <= '0;
            y_cnt_reg <= '0;
        end else begin
            if (vsync_rise || href_fall)
                x_cnt_reg <= '0;
            else if (pix_pulse_reg && (x_cnt_reg != '1))
                x_cnt_reg <= x_cnt_reg + 1'b1;

            if (vsync_rise)
                y_cnt_reg <= '0;
            else if (href_fall && (y_cnt_reg != '1))
                y_cnt_reg <= y_cnt_reg + 1'b1;
        end
    end

    assign in_window = (x_cnt_reg < h_disp) && (y_cnt_reg < v_disp);
`else
    logic unused_cfg;
    assign unused_cfg = ^{h_disp, v_disp};
    assign in_window  = 1'b1;
`endif

    // Output stage: the strobe lands two cycles after the second byte is
    // sampled, with the pixel captured in the same edge so it is stable.
    always_ff @(posedge cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg    <= 1'b0;
            data_out_reg <= '0;
        end else begin
            valid_reg <= pix_pulse_reg & frame_ok & in_window;
            if (pix_pulse_reg) data_out_reg <= pix_reg;
        end
    end

    assign cam.cmos_frame_vsync = vsync_d1 & frame_ok;
    assign cam.cmos_frame_href  = href_d1 & frame_ok;
    assign cam.cmos_frame_valid = valid_reg;
    assign cam.cmos_frame_data  = data_out_reg;
    assign line_err             = line_err_reg;
endmodule

// File: tb/tb_cmos_capture_data.sv
`timescale 1ns/1ps
module tb_cmos_capture_data;
    import cmos_pkg::*;

    localparam int WAIT = 2;
`ifdef CMOS_CROP_EN
    localparam bit CROP = 1'b1;
`else
    localparam bit CROP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [CNT_W-1:0] h_disp;
    logic [CNT_W-1:0] v_disp;
    logic             line_err;

    cmos_capture_data_if bus ();

    cmos_capture_data #(.WAIT_FRAME(WAIT)) dut (
        .cam_pclk(clk),
        .rst_n   (rst_n),
        .cam     (bus),
        .h_disp  (h_disp),
        .v_disp  (v_disp),
        .line_err(line_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int strobe_total = 0;
    int cyc = 0;

    // Expected outputs, indexed by posedge number modulo 8.
    logic        ev   [8];
    logic [15:0] ed   [8];
    logic        evs  [8];
    logic        ehs  [8];
    logic        eerr [8];

    // Behavioural model state: stream-level view of the camera input.
    int          rises;
    logic        pv, ph;
    int          par;
    logic [7:0]  first;
    int          mx, my;
    logic        merr;

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // Model: every posedge consumes one sampled input. Sync outputs follow
    // one edge later, a pixel strobe two edges after its second byte.
    always @(posedge clk) begin
        int   n;
        logic v, h, ok, w;
        logic [7:0] d;
        cyc++;
        n = cyc;
        ev[(n + 2) % 8] = 1'b0;
        if (!rst_n) begin
            rises = 0; pv = 1'b0; ph = 1'b0; par = 0; mx = 0; my = 0; merr = 1'b0;
            ev[(n + 1) % 8]   = 1'b0;
            evs[(n + 1) % 8]  = 1'b0;
            ehs[(n + 1) % 8]  = 1'b0;
            eerr[(n + 1) % 8] = 1'b0;
        end else begin
            v = bus.cam_vsync;
            h = bus.cam_href;
            d = bus.cam_data;
            if (v && !pv) begin
                rises++;
                mx = 0; my = 0; merr = 1'b0; par = 0;
            end
            ok = (rises >= WAIT);
            if (h) begin
                if (par == 0) begin
                    first = d;
                    par = 1;
                end else begin
                    w = !CROP || ((mx < int'(h_disp)) && (my < int'(v_disp)));
                    ev[(n + 2) % 8] = ok && w;
                    ed[(n + 2) % 8] = {first, d};
                    mx++;
                    par = 0;
                end
            end else if (ph) begin
                if (par != 0) merr = 1'b1;
                par = 0;
                mx = 0;
                my++;
            end
            evs[(n + 1) % 8]  = v && ok;
            ehs[(n + 1) % 8]  = h && ok;
            eerr[(n + 1) % 8] = merr;
            pv = v;
            ph = h;
        end
    end

    // Compare process: every active cycle, all outputs against the model.
    always @(negedge clk) begin
        int s;
        if (rst_n) begin
            s = cyc % 8;
            chk("valid", 32'(bus.cmos_frame_valid), 32'(ev[s]));
            if (ev[s]) chk("data", 32'(bus.cmos_frame_data), 32'(ed[s]));
            chk("vsync_out", 32'(bus.cmos_frame_vsync), 32'(evs[s]));
            chk("href_out", 32'(bus.cmos_frame_href), 32'(ehs[s]));
            chk("line_err", 32'(line_err), 32'(eerr[s]));
            if (bus.cmos_frame_valid === 1'b1) begin
                strobe_total++;
                $display("pixel %0d data=0x%04h t=%0t", strobe_total, bus.cmos_frame_data, $time);
            end
        end
    end

    task automatic drive(logic v, logic h, logic [7:0] d);
        @(negedge clk);
        bus.cam_vsync = v;
        bus.cam_href  = h;
        bus.cam_data  = d;
    endtask

    task automatic idle(int n);
        repeat (n) drive(1'b0, 1'b0, 8'($urandom));
    endtask

    task automatic send_line(int nbytes, int gap);
        for (int i = 0; i < nbytes; i++) drive(1'b0, 1'b1, 8'($urandom));
        idle(gap);
    endtask

    task automatic vsync_pulse(int len);
        idle(2);
        repeat (len) drive(1'b1, 1'b0, 8'h00);
        idle(3);
    endtask

    task automatic frame_chk(string name, int lines, int nbytes, int exp);
        int base;
        #2 base = strobe_total;
        repeat (lines) send_line(nbytes, 4);
        vsync_pulse(2);
        #2 chk(name, 32'(strobe_total - base), 32'(exp));
    endtask

    task automatic outputs_zero(string name);
        chk({name, "_valid"}, 32'(bus.cmos_frame_valid), 32'd0);
        chk({name, "_data"},  32'(bus.cmos_frame_data),  32'd0);
        chk({name, "_vsync"}, 32'(bus.cmos_frame_vsync), 32'd0);
        chk({name, "_href"},  32'(bus.cmos_frame_href),  32'd0);
        chk({name, "_err"},   32'(line_err),             32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        for (int i = 0; i < 8; i++) begin
            ev[i] = 1'b0; ed[i] = '0; evs[i] = 1'b0; ehs[i] = 1'b0; eerr[i] = 1'b0;
        end
        bus.cam_vsync = 1'b0;
        bus.cam_href  = 1'b0;
        bus.cam_data  = 8'h00;
        h_disp = CROP ? 11'd100 : 11'd0;
        v_disp = CROP ? 11'd100 : 11'd0;

        repeat (3) @(negedge clk);
        outputs_zero("reset");
        rst_n = 1'b1;
        idle(3);

        // Frames 1-2 are discarded, frame 3 is fully strobed.
        frame_chk("frame1_strobes", 4, 8, 0);
        frame_chk("frame2_strobes", 4, 8, 0);
        frame_chk("frame3_strobes", 4, 8, 16);

        // Frame 4: pixel assembly and strobe latency.
        idle(2);
        drive(1'b0, 1'b1, 8'hAB);
        drive(1'b0, 1'b1, 8'hCD);
        drive(1'b0, 1'b0, 8'h00);
        chk("abcd_lat1", 32'(bus.cmos_frame_valid), 32'd0);
        drive(1'b0, 1'b0, 8'h00);
        chk("abcd_lat2", 32'(bus.cmos_frame_valid), 32'd0);
        drive(1'b0, 1'b0, 8'h00);
        chk("abcd_valid", 32'(bus.cmos_frame_valid), 32'd1);
        chk("abcd_data", 32'(bus.cmos_frame_data), 32'h0000ABCD);
        drive(1'b0, 1'b0, 8'h00);
        chk("abcd_single", 32'(bus.cmos_frame_valid), 32'd0);
        chk("err_before_odd", 32'(line_err), 32'd0);

        // Odd-length line drops its half pixel and sets a sticky error.
        #2 base = strobe_total;
        send_line(7, 4);
        #2 chk("odd_line_strobes", 32'(strobe_total - base), 32'd3);
        chk("odd_line_err", 32'(line_err), 32'd1);
        send_line(8, 4);
        chk("err_sticky", 32'(line_err), 32'd1);
        vsync_pulse(2);
        chk("err_cleared", 32'(line_err), 32'd0);

        // Frame 5: reset in the middle of a line.
        send_line(8, 4);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 8'($urandom));
        chk("pre_reset_href", 32'(bus.cmos_frame_href), 32'd1);
        #2 rst_n = 1'b0;
        #1 outputs_zero("midline_reset");
        drive(1'b0, 1'b1, 8'($urandom));
        drive(1'b0, 1'b1, 8'($urandom));
        rst_n = 1'b1;
        #2 base = strobe_total;
        send_line(5, 4);
        send_line(8, 4);
        vsync_pulse(2);
        #2 chk("frame5_after_reset", 32'(strobe_total - base), 32'd0);
        frame_chk("frame6_strobes", 4, 8, 0);
        frame_chk("frame7_strobes", 4, 8, 16);

        // Frame 8: crop window (or full strobing with h_disp=0 when cropping is off).
        h_disp = CROP ? 11'd2 : 11'd0;
        v_disp = CROP ? 11'd1 : 11'd0;
        idle(2);
        #2 base = strobe_total;
        send_line(8, 4);
        #2 chk("crop_line0", 32'(strobe_total - base), CROP ? 32'd2 : 32'd4);
        send_line(8, 4);
        send_line(8, 4);
        send_line(8, 4);
        vsync_pulse(2);
        #2 chk("crop_total", 32'(strobe_total - base), CROP ? 32'd2 : 32'd16);

        // Random frames checked by the model.
        for (int f = 0; f < 6; f++) begin
            h_disp = 11'($urandom_range(0, 5));
            v_disp = 11'($urandom_range(0, 5));
            idle(2);
            for (int l = 0; l < int'($urandom_range(1, 5)); l++)
                send_line(int'($urandom_range(1, 12)), int'($urandom_range(1, 4)));
            vsync_pulse(int'($urandom_range(1, 3)));
        end
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
